regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 12 +
 rtl/rr_arbiter2.sv | 40 ++++
 rtl/regfile_wb_arbiter.sv | 77 +++++++
 tb/tb_regfile_wb_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared CPU writeback definitions: default datapath widths, the number of
// writeback requesters and the hard-wired zero register address.
package regfile_wb_arbiter_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int NUM_WB_REQ = 2;

   // Register 0 reads as zero, so writes to it are accepted but never issued.
   localparam logic [ADDR_W_DEF-1:0] ZERO_REG = '0;

endpackage : regfile_wb_arbiter_pkg

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The grant is combinational; the priority
// register moves to the requester that lost (or did not ask) after each grant.
module rr_arbiter2
   import regfile_wb_arbiter_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_WB_REQ-1:0] req,
   input  logic                  en,
   output logic [NUM_WB_REQ-1:0] gnt,
   output logic                  prio
);

   logic prio_q;

   // A lone requester always wins; on contention the priority holder wins.
   always_comb begin
      gnt = '0;
      if (en) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
         endcase
      end
   end

   // Priority passes to the non-granted requester after every grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         prio_q <= 1'b0;
      end else if (gnt != '0) begin
         prio_q <= gnt[0];
      end
   end

   assign prio = prio_q;

endmodule : rr_arbiter2

// File: rtl/regfile_wb_arbiter.sv
// Register file writeback arbiter: merges two writeback requesters onto a
// single register file write port with one cycle of latency.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              hold,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              w_en,
   output logic [ADDR_W-1:0] w_addr,
   output logic [DATA_W-1:0] w_data,
   output logic              prio
);

   logic [NUM_WB_REQ-1:0] req;
   logic [NUM_WB_REQ-1:0] gnt;
   logic                  arb_en;
   logic                  xfer;
   logic [ADDR_W-1:0]     sel_addr;
   logic [DATA_W-1:0]     sel_data;
   logic                  sel_write;
   logic                  w_en_q;

   assign req    = {req1_valid, req0_valid};
   assign arb_en = ~rst & ~hold;

   rr_arbiter2 u_arb (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .en   (arb_en),
      .gnt  (gnt),
      .prio (prio)
   );

   assign req0_ready = gnt[0];
   assign req1_ready = gnt[1];

   // Steer the granted requester's address and data toward the output stage.
   always_comb begin
      xfer      = |gnt;
      sel_addr  = gnt[1] ? req1_addr : req0_addr;
      sel_data  = gnt[1] ? req1_data : req0_data;
      sel_write = xfer && (sel_addr != ADDR_W'(ZERO_REG));
   end

   // Output register stage; zero-register transfers leave address/data untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_en_q <= 1'b0;
         w_addr <= '0;
         w_data <= '0;
      end else begin
         w_en_q <= sel_write;
         if (sel_write) begin
            w_addr <= sel_addr;
            w_data <= sel_data;
         end
      end
   end

   // A write captured just before reset rises must not reach the register file.
   assign w_en = w_en_q & ~rst;

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter with a behavioural writeback model.
module tb_regfile_wb_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int OW = AW + DW + 4;

   logic          clk = 1'b0;
   logic          rst, hold;
   logic          req0_valid, req1_valid, req0_ready, req1_ready;
   logic [AW-1:0] req0_addr, req1_addr, w_addr;
   logic [DW-1:0] req0_data, req1_data, w_data;
   logic          w_en, prio;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: what the outputs should show in the current cycle.
   logic          m_prio, m_wen;
   logic [AW-1:0] m_waddr;
   logic [DW-1:0] m_wdata;

   logic [OW-1:0] obs, expv;

   regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .hold       (hold),
      .req0_valid (req0_valid),
      .req0_addr  (req0_addr),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_addr  (req1_addr),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .w_en       (w_en),
      .w_addr     (w_addr),
      .w_data     (w_data),
      .prio       (prio)
   );

   always #5 clk = ~clk;

   // Which requester should be accepted this cycle, from the arbitration rules.
   function automatic logic [1:0] exp_grant();
      if (rst || hold) return 2'b00;
      if (req0_valid && req1_valid) return (m_prio == 1'b1) ? 2'b10 : 2'b01;
      if (req0_valid) return 2'b01;
      if (req1_valid) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [OW-1:0] exp_outputs();
      logic [1:0] g;
      g = exp_grant();
      return {g[1], g[0], m_wen && !rst, m_prio, m_waddr, m_wdata};
   endfunction

   task automatic set_inputs(input logic r, input logic h,
                             input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                             input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
      rst = r; hold = h;
      req0_valid = v0; req0_addr = a0; req0_data = d0;
      req1_valid = v1; req1_addr = a1; req1_data = d1;
   endtask

   // Advance one clock and update the model from the inputs seen at the edge.
   task automatic model_clock();
      logic [1:0]    g;
      int            winner;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      g      = exp_grant();
      winner = g[1] ? 1 : 0;
      a      = (winner == 1) ? req1_addr : req0_addr;
      d      = (winner == 1) ? req1_data : req0_data;
      @(posedge clk);
      if (rst) begin
         m_prio = 1'b0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
      end else if (g != 2'b00) begin
         m_prio = (winner == 0) ? 1'b1 : 1'b0;
         m_wen  = (a != 0);
         if (a != 0) begin
            m_waddr = a;
            m_wdata = d;
         end
      end else begin
         m_wen = 1'b0;
      end
      #1;
   endtask

   task automatic do_reset();
      set_inputs(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
      model_clock();
   endtask

   task automatic test_reset();
      for (int c = 0; c < 3; c++) begin
         set_inputs(1'b1, 1'($urandom_range(0, 1)), 1'b1, AW'($urandom_range(1, 31)), $urandom,
                    1'b1, AW'($urandom_range(1, 31)), $urandom);
         #2; obs = {req1_ready, req0_ready, w_en, prio, w_addr, w_data}; expv = exp_outputs();
         n_tests++;
         if (obs !== expv) begin
            n_fail++;
            $display("[TB] FAIL test_reset cycle %0d: got %h, expected %h", c, obs, expv);
         end
         model_clock();
      end
   endtask

   task automatic test_single_write();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         if (c == 0) set_inputs(1'b0, 1'b0, 1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0);
         else        set_inputs(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
         #2; obs = {req1_ready, req0_ready, w_en, prio, w_addr, w_data}; expv = exp_outputs();
         n_tests++;
         if (obs !== expv) begin
            n_fail++;
            $display("[TB] FAIL test_single_write cycle %0d: got %h, expected %h", c, obs, expv);
         end
         model_clock();
      end
   endtask

   task automatic test_alternation();
      do_reset();
      for (int c = 0; c < 5; c++) begin
         if (c < 4) set_inputs(1'b0, 1'b0, 1'b1, 5'd1, DW'(32'h100 + c), 1'b1, 5'd2, DW'(32'h200 + c));
         else       set_inputs(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
         #2; obs = {req1_ready, req0_ready, w_en, prio, w_addr, w_data}; expv = exp_outputs();
         n_tests++;
         if (obs !== expv) begin
            n_fail++;
            $display("[TB] FAIL test_alternation cycle %0d: got %h, expected %h", c, obs, expv);
         end
         model_clock();
      end
   endtask

   task automatic test_zero_addr();
      for (int c = 0; c < 3; c++) begin
         case (c)
            0:       set_inputs(1'b0, 1'b0, 1'b1, 5'd9, 32'h5A5A, 1'b0, 5'd0, 32'h0);
            1:       set_inputs(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFF);
            default: set_inputs(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
         endcase
         #2; obs = {req1_ready, req0_ready, w_en, prio, w_addr, w_data}; expv = exp_outputs();
         n_tests++;
         if (obs !== expv) begin
            n_fail++;
            $display("[TB] FAIL test_zero_addr cycle %0d: got %h, expected %h", c, obs, expv);
         end
         model_clock();
      end
   endtask

   task automatic test_hold();
      do_reset();
      for (int c = 0; c < 7; c++) begin
         if (c == 0)     set_inputs(1'b0, 1'b0, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0);
         else if (c < 4) set_inputs(1'b0, 1'b1, 1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2);
         else if (c < 6) set_inputs(1'b0, 1'b0, 1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2);
         else            set_inputs(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
         #2; obs = {req1_ready, req0_ready, w_en, prio, w_addr, w_data}; expv = exp_outputs();
         n_tests++;
         if (obs !== expv) begin
            n_fail++;
            $display("[TB] FAIL test_hold cycle %0d: got %h, expected %h", c, obs, expv);
         end
         model_clock();
      end
   endtask

   task automatic test_reset_discard();
      for (int c = 0; c < 3; c++) begin
         case (c)
            0:       set_inputs(1'b0, 1'b0, 1'b1, 5'd5, 32'hAA, 1'b0, 5'd0, 32'h0);
            1:       set_inputs(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
            default: set_inputs(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
         endcase
         #2; obs = {req1_ready, req0_ready, w_en, prio, w_addr, w_data}; expv = exp_outputs();
         n_tests++;
         if (obs !== expv) begin
            n_fail++;
            $display("[TB] FAIL test_reset_discard cycle %0d: got %h, expected %h", c, obs, expv);
         end
         model_clock();
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int c = 0; c < 4; c++) begin
         case (c)
            0:       set_inputs(1'b0, 1'b0, 1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2);
            1:       set_inputs(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h2);
            default: set_inputs(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
         endcase
         #2; obs = {req1_ready, req0_ready, w_en, prio, w_addr, w_data}; expv = exp_outputs();
         n_tests++;
         if (obs !== expv) begin
            n_fail++;
            $display("[TB] FAIL test_back_to_back cycle %0d: got %h, expected %h", c, obs, expv);
         end
         model_clock();
      end
   endtask

   task automatic test_random();
      logic          keep0, keep1, r, h, v0, v1;
      logic [AW-1:0] a0, a1;
      logic [DW-1:0] d0, d1;
      logic [1:0]    g;
      keep0 = 1'b0; keep1 = 1'b0;
      v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
      for (int c = 0; c < 400; c++) begin
         if (!keep0) begin
            v0 = ($urandom_range(0, 2) != 0); a0 = AW'($urandom_range(0, 7)); d0 = $urandom;
         end
         if (!keep1) begin
            v1 = ($urandom_range(0, 2) != 0); a1 = AW'($urandom_range(0, 7)); d1 = $urandom;
         end
         r = ($urandom_range(0, 29) == 0);
         h = ($urandom_range(0, 4) == 0);
         set_inputs(r, h, v0, a0, d0, v1, a1, d1);
         #2; obs = {req1_ready, req0_ready, w_en, prio, w_addr, w_data}; expv = exp_outputs();
         n_tests++;
         if (obs !== expv) begin
            n_fail++;
            $display("[TB] FAIL test_random cycle %0d: got %h, expected %h", c, obs, expv);
         end
         g = exp_grant();
         keep0 = v0 && !g[0] && !r;
         keep1 = v1 && !g[1] && !r;
         model_clock();
      end
   endtask

   initial begin
      set_inputs(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      m_prio = 1'b0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
      test_reset();
      test_single_write();
      test_alternation();
      test_zero_addr();
      test_hold();
      test_reset_discard();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule : tb_regfile_wb_arbiter
